// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Operand bypass and load-use hazard control for the MIPS pipeline.
//   This block sits between ID and the ID/EX register. For each decode read
//   port it picks the youngest in-flight producer (EX > MEM > WB) and drives
//   the operand mux. Register r0 is never bypassed. On a load-use hazard it
//   holds PC and IF/ID and injects bubbles into EX for LOAD_LATENCY enabled
//   cycles. It also keeps a saturating count of stalled cycles for debug.
//
// Ports
//   i_clock, i_reset   clock; synchronous active-high reset
//   i_enable           pipeline advance; 0 freezes all state
//   i_clr_cnt          clear the stall-cycle counter
//   i_rs, i_use        per-port read address and read-valid
//   i_we_*, i_rd_*,    per-stage write enable, destination, result
//   i_data_*, i_load_ex
//   o_data, o_mux      per-port bypass data and operand mux select
//   o_stall, o_bubble  IF/ID hold and ID/EX flush
//   o_stall_cycles     saturating stalled-cycle count
module forward_hazard_unit #(
  parameter int unsigned NB_REG_ADDR  = 5,
  parameter int unsigned NB_REG       = 32,
  parameter int unsigned N_PORTS      = 2,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned NB_CNT       = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_clr_cnt,
  input  logic [N_PORTS*NB_REG_ADDR-1:0] i_rs,
  input  logic [N_PORTS-1:0]             i_use,
  input  logic                           i_we_ex,
  input  logic                           i_we_mem,
  input  logic                           i_we_wb,
  input  logic                           i_load_ex,
  input  logic [NB_REG_ADDR-1:0]         i_rd_ex,
  input  logic [NB_REG_ADDR-1:0]         i_rd_mem,
  input  logic [NB_REG_ADDR-1:0]         i_rd_wb,
  input  logic [NB_REG-1:0]              i_data_ex,
  input  logic [NB_REG-1:0]              i_data_mem,
  input  logic [NB_REG-1:0]              i_data_wb,
  output logic [N_PORTS*NB_REG-1:0]      o_data,
  output logic [N_PORTS-1:0]             o_mux,
  output logic                           o_stall,
  output logic                           o_bubble,
  output logic [NB_CNT-1:0]              o_stall_cycles
);

  localparam int unsigned NbLcnt = $clog2(LOAD_LATENCY + 1);

  typedef enum logic {StIdle, StStall} state_e;

  state_e              state_q, state_d;
  logic [NbLcnt-1:0]   cnt_q, cnt_d;
  logic [NB_CNT-1:0]   stall_cycles_q, stall_cycles_d;
  logic [N_PORTS-1:0]  haz_vec;
  logic                haz;
  logic                stall_raw;

  // Per-port bypass selection; ports are fully independent.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [NB_REG_ADDR-1:0] rs;
    logic                   rs_nz;
    logic                   hit_ex, hit_mem, hit_wb;

    assign rs      = i_rs[p*NB_REG_ADDR +: NB_REG_ADDR];
    assign rs_nz   = (rs != '0);
    // A load in EX has no result yet, so it cannot feed the EX bypass.
    assign hit_ex  = i_use[p] & i_we_ex & ~i_load_ex & (rs == i_rd_ex) & rs_nz;
    assign hit_mem = i_use[p] & i_we_mem & (rs == i_rd_mem) & rs_nz;
    assign hit_wb  = i_use[p] & i_we_wb & (rs == i_rd_wb) & rs_nz;
    assign haz_vec[p] = i_use[p] & i_we_ex & i_load_ex & (rs == i_rd_ex) & rs_nz;

    assign o_mux[p] = hit_ex | hit_mem | hit_wb;
    assign o_data[p*NB_REG +: NB_REG] = hit_ex  ? i_data_ex  :
                                        hit_mem ? i_data_mem :
                                        hit_wb  ? i_data_wb  : '0;
  end

  assign haz = |haz_vec;

  // In StStall, EX holds a bubble, so a fresh hazard cannot be observed there.
  assign stall_raw = (state_q == StStall) | haz;
  assign o_stall   = stall_raw & ~i_reset;
  assign o_bubble  = stall_raw & ~i_reset;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;
    if (i_enable) begin
      unique case (state_q)
        StIdle: begin
          // The IDLE hazard cycle is the first of LOAD_LATENCY stall cycles.
          if (haz && (LOAD_LATENCY > 1)) begin
            state_d = StStall;
            cnt_d   = NbLcnt'(LOAD_LATENCY - 1);
          end
        end
        StStall: begin
          cnt_d = cnt_q - NbLcnt'(1);
          if (cnt_q == NbLcnt'(1)) begin
            state_d = StIdle;
          end
        end
      endcase

      if (i_clr_cnt) begin
        stall_cycles_d = '0;
      end else if (o_stall && (stall_cycles_q != {NB_CNT{1'b1}})) begin
        stall_cycles_d = stall_cycles_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  logic        clk;
  logic        i_reset, i_enable, i_clr_cnt;
  logic [9:0]  i_rs;
  logic [1:0]  i_use;
  logic        i_we_ex, i_we_mem, i_we_wb, i_load_ex;
  logic [4:0]  i_rd_ex, i_rd_mem, i_rd_wb;
  logic [31:0] i_data_ex, i_data_mem, i_data_wb;

  logic [63:0] data1, data3, datac;
  logic [1:0]  mux1, mux3, muxc;
  logic        stall1, stall3, stallc, bub1, bub3, bubc;
  logic [15:0] sc1, sc3;
  logic [3:0]  scc;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LOAD_LATENCY=1, 16-bit counter
  forward_hazard_unit #(.LOAD_LATENCY(1), .NB_CNT(16)) u_dut1 (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clr_cnt(i_clr_cnt),
    .i_rs(i_rs), .i_use(i_use), .i_we_ex(i_we_ex), .i_we_mem(i_we_mem), .i_we_wb(i_we_wb),
    .i_load_ex(i_load_ex), .i_rd_ex(i_rd_ex), .i_rd_mem(i_rd_mem), .i_rd_wb(i_rd_wb),
    .i_data_ex(i_data_ex), .i_data_mem(i_data_mem), .i_data_wb(i_data_wb),
    .o_data(data1), .o_mux(mux1), .o_stall(stall1), .o_bubble(bub1), .o_stall_cycles(sc1)
  );

  // LOAD_LATENCY=3
  forward_hazard_unit #(.LOAD_LATENCY(3), .NB_CNT(16)) u_dut3 (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clr_cnt(i_clr_cnt),
    .i_rs(i_rs), .i_use(i_use), .i_we_ex(i_we_ex), .i_we_mem(i_we_mem), .i_we_wb(i_we_wb),
    .i_load_ex(i_load_ex), .i_rd_ex(i_rd_ex), .i_rd_mem(i_rd_mem), .i_rd_wb(i_rd_wb),
    .i_data_ex(i_data_ex), .i_data_mem(i_data_mem), .i_data_wb(i_data_wb),
    .o_data(data3), .o_mux(mux3), .o_stall(stall3), .o_bubble(bub3), .o_stall_cycles(sc3)
  );

  // 4-bit counter for saturation
  forward_hazard_unit #(.LOAD_LATENCY(1), .NB_CNT(4)) u_dutc (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clr_cnt(i_clr_cnt),
    .i_rs(i_rs), .i_use(i_use), .i_we_ex(i_we_ex), .i_we_mem(i_we_mem), .i_we_wb(i_we_wb),
    .i_load_ex(i_load_ex), .i_rd_ex(i_rd_ex), .i_rd_mem(i_rd_mem), .i_rd_wb(i_rd_wb),
    .i_data_ex(i_data_ex), .i_data_mem(i_data_mem), .i_data_wb(i_data_wb),
    .o_data(datac), .o_mux(muxc), .o_stall(stallc), .o_bubble(bubc), .o_stall_cycles(scc)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs0, rs1;
    logic [1:0]  use_m;
    logic        we_ex, we_mem, we_wb, load;
    logic [4:0]  rd_ex, rd_mem, rd_wb;
    logic [1:0]  mux;
    logic [31:0] q0, q1;
    logic        stall;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string nm, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [1:0] u, input logic wex, input logic wmem,
                              input logic wwb, input logic ld, input logic [4:0] rdex,
                              input logic [4:0] rdmem, input logic [4:0] rdwb,
                              input logic [1:0] mx, input logic [31:0] q0,
                              input logic [31:0] q1, input logic st);
    vec_t v;
    v.name = nm; v.rs0 = rs0; v.rs1 = rs1; v.use_m = u;
    v.we_ex = wex; v.we_mem = wmem; v.we_wb = wwb; v.load = ld;
    v.rd_ex = rdex; v.rd_mem = rdmem; v.rd_wb = rdwb;
    v.mux = mx; v.q0 = q0; v.q1 = q1; v.stall = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_enable = 1'b1; i_clr_cnt = 1'b0;
    i_rs = '0; i_use = '0;
    i_we_ex = 1'b0; i_we_mem = 1'b0; i_we_wb = 1'b0; i_load_ex = 1'b0;
    i_rd_ex = '0; i_rd_mem = '0; i_rd_wb = '0;
    i_data_ex = 32'h11; i_data_mem = 32'h22; i_data_wb = 32'h33;
  endtask

  // Load to r7 in EX, read by port 1.
  task automatic load_hazard();
    i_rs = {5'd7, 5'd0}; i_use = 2'b10;
    i_we_ex = 1'b1; i_load_ex = 1'b1; i_rd_ex = 5'd7;
  endtask

  // Called at a negedge; returns at the negedge after reset has been applied.
  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    vecs[0] = mk("prio_ex",   5, 5, 2'b11, 1, 1, 1, 0, 5, 5, 5,  2'b11, 32'h11, 32'h11, 0);
    vecs[1] = mk("prio_mem",  5, 5, 2'b11, 0, 1, 1, 0, 5, 5, 5,  2'b11, 32'h22, 32'h22, 0);
    vecs[2] = mk("prio_wb",   5, 5, 2'b11, 0, 0, 1, 0, 5, 5, 5,  2'b11, 32'h33, 32'h33, 0);
    vecs[3] = mk("r0_filter", 0, 0, 2'b11, 1, 1, 1, 1, 0, 0, 0,  2'b00, 32'h0,  32'h0,  0);
    vecs[4] = mk("use_mask",  5, 5, 2'b01, 1, 1, 1, 0, 5, 5, 5,  2'b01, 32'h11, 32'h0,  0);
    vecs[5] = mk("indep",     5, 9, 2'b11, 1, 1, 1, 0, 5, 9, 9,  2'b11, 32'h11, 32'h22, 0);
    vecs[6] = mk("load_mem",  3, 7, 2'b11, 1, 1, 0, 1, 7, 7, 0,  2'b10, 32'h0,  32'h22, 1);
    vecs[7] = mk("load_nouse",3, 7, 2'b01, 1, 0, 0, 1, 7, 0, 0,  2'b00, 32'h0,  32'h0,  0);
    vecs[8] = mk("wb_port1",  0, 12, 2'b11, 0, 0, 1, 0, 0, 0, 12, 2'b10, 32'h0,  32'h33, 0);
    vecs[9] = mk("load_p0",   4, 4, 2'b01, 1, 0, 0, 1, 4, 0, 0,  2'b00, 32'h0,  32'h0,  1);

    // Reset: outputs forced low even with a hazard present.
    idle_inputs();
    i_reset = 1'b1;
    load_hazard();
    @(negedge clk);
    #1;
    check("rst_stall_forced", stall1, 1'b0);
    check("rst_bubble_forced", bub1, 1'b0);
    check("rst_cnt", sc1, 16'd0);
    idle_inputs();
    i_reset = 1'b0;
    #1;
    check("rst_mux", mux1, 2'b00);
    check("rst_stall3", stall3, 1'b0);
    @(negedge clk);

    // Combinational table with state frozen.
    for (int i = 0; i < 10; i++) begin
      i_enable = 1'b0;
      i_rs = {vecs[i].rs1, vecs[i].rs0}; i_use = vecs[i].use_m;
      i_we_ex = vecs[i].we_ex; i_we_mem = vecs[i].we_mem; i_we_wb = vecs[i].we_wb;
      i_load_ex = vecs[i].load;
      i_rd_ex = vecs[i].rd_ex; i_rd_mem = vecs[i].rd_mem; i_rd_wb = vecs[i].rd_wb;
      #1;
      check({vecs[i].name, "_mux"}, mux1, vecs[i].mux);
      check({vecs[i].name, "_q0"}, data1[31:0], vecs[i].q0);
      check({vecs[i].name, "_q1"}, data1[63:32], vecs[i].q1);
      check({vecs[i].name, "_stall"}, stall1, vecs[i].stall);
      check({vecs[i].name, "_bubble"}, bub1, vecs[i].stall);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("frozen_cnt", sc1, 16'd0);
    check("frozen_no_stall3", stall3, 1'b0);

    // LOAD_LATENCY=1: one stall cycle, then bypass from MEM.
    do_reset();
    load_hazard();
    #1;
    check("ll1_stall", stall1, 1'b1);
    check("ll1_bubble", bub1, 1'b1);
    @(negedge clk);
    idle_inputs();
    i_rs = {5'd7, 5'd0}; i_use = 2'b10;
    i_we_mem = 1'b1; i_rd_mem = 5'd7; i_data_mem = 32'hABCD;
    #1;
    check("ll1_stall_done", stall1, 1'b0);
    check("ll1_mux", mux1, 2'b10);
    check("ll1_data", data1[63:32], 32'hABCD);
    check("ll1_cnt", sc1, 16'd1);
    @(negedge clk);

    // LOAD_LATENCY=3 with a two-cycle freeze mid-stall.
    do_reset();
    load_hazard();
    #1;
    check("ll3_c0", stall3, 1'b1);
    @(negedge clk);
    idle_inputs();
    i_enable = 1'b0;
    #1;
    check("ll3_frz0", stall3, 1'b1);
    @(negedge clk);
    #1;
    check("ll3_frz1", stall3, 1'b1);
    check("ll3_frz_cnt", sc3, 16'd1);
    @(negedge clk);
    i_enable = 1'b1;
    #1;
    check("ll3_c1", stall3, 1'b1);
    check("ll3_c1_bubble", bub3, 1'b1);
    @(negedge clk);
    #1;
    check("ll3_c2", stall3, 1'b1);
    @(negedge clk);
    #1;
    check("ll3_end", stall3, 1'b0);
    check("ll3_cnt", sc3, 16'd3);
    @(negedge clk);

    // Reset in the middle of a stall.
    do_reset();
    load_hazard();
    @(negedge clk);
    idle_inputs();
    #1;
    check("rmid_stall", stall3, 1'b1);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    check("rmid_rst_stall", stall3, 1'b0);
    check("rmid_rst_bubble", bub3, 1'b0);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    check("rmid_after_stall", stall3, 1'b0);
    check("rmid_after_cnt", sc3, 16'd0);
    @(negedge clk);
    #1;
    check("rmid_idle", stall3, 1'b0);

    // Saturation of a 4-bit counter, then clear during a stalled cycle.
    do_reset();
    load_hazard();
    for (int i = 0; i < 15; i++) @(negedge clk);
    #1;
    check("sat_15", scc, 4'd15);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    check("sat_20", scc, 4'd15);
    check("nosat_20", sc1, 16'd20);
    check("sat_stall", stallc, 1'b1);
    i_clr_cnt = 1'b1;
    @(negedge clk);
    i_clr_cnt = 1'b0;
    #1;
    check("clr", scc, 4'd0);
    @(negedge clk);
    #1;
    check("after_clr", scc, 4'd1);
    idle_inputs();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
